// File: rtl/rev_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rev_pkg
// Description : Shared types for the reversible-gate sequencer: gate opcodes,
//               packed gate descriptor and FSM state encoding.
//               Optional undo support is selected with REV_UNDO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package rev_pkg;

    // Widest index any configuration needs (LINES up to 64).
    localparam int c_IDX_W = 6;

    typedef enum logic [1:0] {
        OP_NOT  = 2'b00,
        OP_CNOT = 2'b01,
        OP_TOF  = 2'b10,
        OP_FRED = 2'b11
    } gate_op_e;

    typedef struct packed {
        gate_op_e             op;
        logic [c_IDX_W-1:0]   a;
        logic [c_IDX_W-1:0]   b;
        logic [c_IDX_W-1:0]   c;
    } gate_t;

`ifdef REV_UNDO_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2,
        UNDO  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;
`endif

endpackage
`default_nettype wire

// File: rtl/rev_gate_apply.sv
`default_nettype none
// ============================================================================
// Module      : rev_gate_apply
// Description : Combinational evaluation of one NOT/CNOT/Toffoli/Fredkin gate
//               on a wire vector, with legality checking.
// Revision    : 1.0 - initial release
// ============================================================================
module rev_gate_apply
    import rev_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDXW  = $clog2(LINES)
) (
    input  logic [LINES-1:0] s_in,
    input  gate_t            gate,
    input  logic             en,
    output logic [LINES-1:0] s_out,
    output logic             illegal
);

    logic            w_a_oob;
    logic            w_b_oob;
    logic            w_c_oob;
    logic [IDXW-1:0] w_a;
    logic [IDXW-1:0] w_b;
    logic [IDXW-1:0] w_c;

    always_comb begin
        w_a_oob = int'(gate.a) >= LINES;
        w_b_oob = int'(gate.b) >= LINES;
        w_c_oob = int'(gate.c) >= LINES;
        w_a     = gate.a[IDXW-1:0];
        w_b     = gate.b[IDXW-1:0];
        w_c     = gate.c[IDXW-1:0];

        case (gate.op)
            OP_NOT:  illegal = w_c_oob;
            OP_CNOT: illegal = w_a_oob | w_c_oob | (gate.a == gate.c);
            OP_TOF:  illegal = w_a_oob | w_b_oob | w_c_oob |
                               (gate.c == gate.a) | (gate.c == gate.b);
            OP_FRED: illegal = w_a_oob | w_b_oob | w_c_oob |
                               (gate.a == gate.b) | (gate.a == gate.c);
            default: illegal = 1'b1;
        endcase

        s_out = s_in;
        // Out-of-range indices are only ever dereferenced when the gate is legal.
        if (en && !illegal) begin
            case (gate.op)
                OP_NOT:  s_out[w_c] = ~s_in[w_c];
                OP_CNOT: s_out[w_c] = s_in[w_c] ^ s_in[w_a];
                OP_TOF:  s_out[w_c] = s_in[w_c] ^ (s_in[w_a] & s_in[w_b]);
                OP_FRED: begin
                    if (s_in[w_a]) begin
                        s_out[w_b] = s_in[w_c];
                        s_out[w_c] = s_in[w_b];
                    end
                end
                default: s_out = s_in;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rev_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rev_gate_sequencer
// Description : Loads a wire vector, applies a streamed gate program one gate
//               per clock, returns the result over a valid/ready handshake.
//               Define REV_UNDO_EN to enable LIFO-based reverse playback.
// Revision    : 1.0 - initial release
// ============================================================================
module rev_gate_sequencer
    import rev_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDXW  = $clog2(LINES),
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LINES-1:0] in_data,
    input  logic             gate_valid,
    output logic             gate_ready,
    input  logic [1:0]       gate_op,
    input  logic [IDXW-1:0]  gate_a,
    input  logic [IDXW-1:0]  gate_b,
    input  logic [IDXW-1:0]  gate_c,
    input  logic             gate_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LINES-1:0] out_data,
    output logic             err,
    input  logic             undo_req
);

    state_e           r_state;
    state_e           w_state_nx;
    logic [LINES-1:0] r_s;
    logic [LINES-1:0] w_s_next;
    logic             r_err;
    logic             w_illegal;
    logic             w_en;
    gate_t            w_gate_in;
    gate_t            w_gate;

    assign w_gate_in = '{op: gate_op_e'(gate_op),
                         a:  c_IDX_W'(gate_a),
                         b:  c_IDX_W'(gate_b),
                         c:  c_IDX_W'(gate_c)};

`ifdef REV_UNDO_EN
    localparam int c_SPW = $clog2(DEPTH + 1);
    localparam int c_HW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    gate_t            r_hist [DEPTH];
    logic [c_SPW-1:0] r_sp;
    logic             r_ovf;
    logic [c_SPW-1:0] w_sp_dec;

    assign w_sp_dec = r_sp - 1'b1;
    // Every gate is self-inverse, so replaying the stored gate undoes it.
    assign w_gate   = (r_state == UNDO) ? r_hist[c_HW'(w_sp_dec)] : w_gate_in;
    assign w_en     = ((r_state == APPLY) && gate_valid) || (r_state == UNDO);
`else
    assign w_gate   = w_gate_in;
    assign w_en     = (r_state == APPLY) && gate_valid;
`endif

    rev_gate_apply #(
        .LINES (LINES),
        .IDXW  (IDXW)
    ) u_apply (
        .s_in    (r_s),
        .gate    (w_gate),
        .en      (w_en),
        .s_out   (w_s_next),
        .illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nx = APPLY;
            APPLY:   if (gate_valid && gate_last) w_state_nx = DONE;
            DONE: begin
                if (out_ready) w_state_nx = IDLE;
`ifdef REV_UNDO_EN
                else if (undo_req && !r_ovf && (r_sp != '0)) w_state_nx = UNDO;
`endif
            end
`ifdef REV_UNDO_EN
            UNDO:    if (r_sp == c_SPW'(1)) w_state_nx = DONE;
`endif
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s   <= '0;
            r_err <= 1'b0;
`ifdef REV_UNDO_EN
            r_sp  <= '0;
            r_ovf <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s   <= in_data;
                        r_err <= 1'b0;
`ifdef REV_UNDO_EN
                        r_sp  <= '0;
                        r_ovf <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    if (gate_valid) begin
                        r_s <= w_s_next;
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end
`ifdef REV_UNDO_EN
                        else if (r_sp < c_SPW'(DEPTH)) begin
                            r_hist[c_HW'(r_sp)] <= w_gate_in;
                            r_sp                <= r_sp + 1'b1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
`endif
                    end
                end
`ifdef REV_UNDO_EN
                UNDO: begin
                    r_s  <= w_s_next;
                    r_sp <= w_sp_dec;
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign gate_ready = (r_state == APPLY);
    assign out_valid  = (r_state == DONE);
    assign out_data   = r_s;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rev_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rev_gate_sequencer
// Description : Directed self-checking bench for rev_gate_sequencer (LINES=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rev_gate_sequencer;

    localparam int c_LINES = 8;
    localparam int c_IDXW  = 3;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [c_LINES-1:0] in_data;
    logic               gate_valid;
    logic               gate_ready;
    logic [1:0]         gate_op;
    logic [c_IDXW-1:0]  gate_a;
    logic [c_IDXW-1:0]  gate_b;
    logic [c_IDXW-1:0]  gate_c;
    logic               gate_last;
    logic               out_valid;
    logic               out_ready;
    logic [c_LINES-1:0] out_data;
    logic               err;
    logic               undo_req;

    int n_cmp;
    int n_bad;

    rev_gate_sequencer #(
        .LINES (c_LINES),
        .IDXW  (c_IDXW),
        .DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .gate_valid (gate_valid),
        .gate_ready (gate_ready),
        .gate_op    (gate_op),
        .gate_a     (gate_a),
        .gate_b     (gate_b),
        .gate_c     (gate_c),
        .gate_last  (gate_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err        (err),
        .undo_req   (undo_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic gate(input logic [1:0] op, input int a, input int b, input int c,
                        input logic last);
        gate_valid = 1'b1;
        gate_op    = op;
        gate_a     = c_IDXW'(a);
        gate_b     = c_IDXW'(b);
        gate_c     = c_IDXW'(c);
        gate_last  = last;
        step();
        gate_valid = 1'b0;
        gate_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; gate_valid = 1'b0;
        gate_op = 2'b00; gate_a = '0; gate_b = '0; gate_c = '0; gate_last = 1'b0;
        out_ready = 1'b0; undo_req = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready",   64'(in_ready),   64'd1);
        chk("rst_gate_ready", 64'(gate_ready), 64'd0);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_data",   64'(out_data),   64'h00);
        chk("rst_err",        64'(err),        64'd0);

        // Fredkin with control set swaps wires 1 and 3
        load(8'h03);
        chk("t1_gate_ready", 64'(gate_ready), 64'd1);
        chk("t1_in_ready",   64'(in_ready),   64'd0);
        chk("t1_out_valid0", 64'(out_valid),  64'd0);
        gate(2'b11, 0, 1, 3, 1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data",  64'(out_data),  64'h09);
        chk("t1_err",       64'(err),       64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_out_valid",  64'(out_valid),  64'd1);
            chk("hold_out_data",   64'(out_data),   64'h09);
            chk("hold_in_ready",   64'(in_ready),   64'd0);
            chk("hold_gate_ready", 64'(gate_ready), 64'd0);
        end
        release_out();
        chk("t1_idle_in_ready",  64'(in_ready),  64'd1);
        chk("t1_idle_out_valid", 64'(out_valid), 64'd0);

        // Toffoli then CNOT with an idle gap between them
        load(8'h03);
        gate(2'b10, 0, 1, 7, 1'b0);
        chk("t2_mid_data", 64'(out_data), 64'h83);
        step();
        chk("t2_gap_gate_ready", 64'(gate_ready), 64'd1);
        chk("t2_gap_out_valid",  64'(out_valid),  64'd0);
        gate(2'b01, 7, 0, 6, 1'b1);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_out_data",  64'(out_data),  64'hC3);
        release_out();

        // Illegal CNOT a==c is a no-op that sets err
        load(8'h04);
        gate(2'b01, 2, 0, 2, 1'b1);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        chk("t3_out_data",  64'(out_data),  64'h04);
        chk("t3_err",       64'(err),       64'd1);
        release_out();
        chk("t3_err_kept_idle", 64'(err), 64'd1);
        load(8'h10);
        chk("t3_err_cleared", 64'(err), 64'd0);
        gate(2'b00, 0, 0, 4, 1'b0);
        chk("t3_not_once", 64'(out_data), 64'h00);
        gate(2'b00, 0, 0, 4, 1'b1);
        chk("t3_not_twice", 64'(out_data), 64'h10);
        chk("t3_not_err",   64'(err),      64'd0);
        release_out();

        // Mixed legal and illegal Toffoli/Fredkin
        load(8'h01);
        gate(2'b10, 0, 2, 2, 1'b0);
        chk("t4_tof_cb_noop", 64'(out_data), 64'h01);
        chk("t4_tof_cb_err",  64'(err),      64'd1);
        gate(2'b01, 0, 0, 5, 1'b0);
        chk("t4_cnot", 64'(out_data), 64'h21);
        gate(2'b11, 5, 5, 1, 1'b0);
        chk("t4_fred_ab_noop", 64'(out_data), 64'h21);
        gate(2'b11, 3, 0, 5, 1'b0);
        chk("t4_fred_ctl0", 64'(out_data), 64'h21);
        gate(2'b11, 0, 1, 5, 1'b1);
        chk("t4_out_data", 64'(out_data), 64'h03);
        chk("t4_err",      64'(err),      64'd1);
        release_out();

        // Undo request on a three-gate frame
        load(8'h5A);
        gate(2'b00, 0, 0, 0, 1'b0);
        gate(2'b10, 1, 3, 5, 1'b0);
        gate(2'b11, 4, 2, 7, 1'b1);
        chk("t5_out_data", 64'(out_data), 64'h7B);
        undo_req = 1'b1;
        step();
        undo_req = 1'b0;
`ifdef REV_UNDO_EN
        chk("t5_undo_v1", 64'(out_valid), 64'd0);
        step();
        chk("t5_undo_v2", 64'(out_valid), 64'd0);
        step();
        chk("t5_undo_v3", 64'(out_valid), 64'd0);
        step();
        chk("t5_undo_done", 64'(out_valid), 64'd1);
        chk("t5_undo_data", 64'(out_data),  64'h5A);
`else
        chk("t5_ignored_valid", 64'(out_valid), 64'd1);
        chk("t5_ignored_data",  64'(out_data),  64'h7B);
        step();
        chk("t5_ignored_valid2", 64'(out_valid), 64'd1);
`endif
        // out_ready wins over a simultaneous undo_req
        out_ready = 1'b1;
        undo_req  = 1'b1;
        step();
        out_ready = 1'b0;
        undo_req  = 1'b0;
        chk("t5_ready_wins", 64'(in_ready), 64'd1);

        // Reset mid-frame discards everything
        load(8'hAA);
        gate(2'b00, 0, 0, 0, 1'b0);
        gate(2'b01, 1, 0, 1, 1'b0);
        chk("t6_pre_data", 64'(out_data), 64'hAB);
        chk("t6_pre_err",  64'(err),      64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_out_valid",  64'(out_valid),  64'd0);
        chk("t6_out_data",   64'(out_data),   64'h00);
        chk("t6_err",        64'(err),        64'd0);
        chk("t6_in_ready",   64'(in_ready),   64'd1);
        chk("t6_gate_ready", 64'(gate_ready), 64'd0);
        step();
        chk("t6_stay_idle", 64'(in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
